// File: rtl/proc_ctrl.sv
// proc_ctrl: control unit of a simple multi-cycle processor (mv, mvi, add, sub, optional mvnz)
//
// Ports:
//   Clock   - rising-edge clock for all state
//   Resetn  - asynchronous active-low reset (step counter -> T0, IR -> 0)
//   Run     - start request, sampled in T0
//   DIN     - instruction word in T0 (DIN[8:0] = III XXX YYY); immediate on the bus in mvi T1
//   Gnz     - G register non-zero flag (only used when PROC_CTRL_MVNZ_EN is defined)
//   Rout    - one-hot bus-source select, Rout[n] drives Rn
//   Gout    - bus-source select for G
//   DINout  - bus-source select for DIN
//   Rin     - one-hot register load enable, Rin[n] loads Rn from the bus
//   IRin    - IR load enable
//   Ain     - A load enable
//   Gin     - G load enable
//   AddSub  - ALU operation, 0 = add, 1 = sub
//   Done    - instruction complete; the following edge returns to T0
//
// Optional feature: define PROC_CTRL_MVNZ_EN to turn opcode 100 into mvnz
// (move Ry to Rx only when Gnz is high). Without it opcode 100 is a NOP.
module proc_ctrl (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [15:0] DIN,
    input  logic        Gnz,
    output logic [0:7]  Rout,
    output logic        Gout,
    output logic        DINout,
    output logic [0:7]  Rin,
    output logic        IRin,
    output logic        Ain,
    output logic        Gin,
    output logic        AddSub,
    output logic        Done
);
    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    step_t      step, step_nxt;
    logic [8:0] ir;
    logic [2:0] op, rx, ry;
    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];
`ifdef PROC_CTRL_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
    logic [6:0] unused_din;
    assign unused_din = DIN[15:9];
`else
    logic [7:0] unused_in;
    assign unused_in = {DIN[15:9], Gnz};
`endif
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            step <= T0;
            ir   <= '0;
        end else begin
            step <= step_nxt;
            if (IRin) ir <= DIN[8:0];
        end
    always_comb begin
        Rout   = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Rin    = '0;
        IRin   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        case (step)
            T0: IRin = Run;
            T1:
                case (op)
                    OP_MV: begin
                        Rout[ry] = 1'b1;
                        Rin[rx]  = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        Rin[rx] = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout[rx] = 1'b1;
                        Ain      = 1'b1;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    // conditional move: the select/load pair is gated together so the bus is never left driven without a load
                    OP_MVNZ: begin
                        Rout[ry] = Gnz;
                        Rin[rx]  = Gnz;
                        Done     = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            // T2/T3 are only reachable by add and sub
            T2: begin
                Rout[ry] = 1'b1;
                Gin      = 1'b1;
                AddSub   = (op == OP_SUB);
            end
            T3: begin
                Gout    = 1'b1;
                Rin[rx] = 1'b1;
                Done    = 1'b1;
            end
            default: ;
        endcase
        step_nxt = (step == T0) ? (Run ? T1 : T0) : (Done ? T0 : step_t'(step + 2'd1));
    end
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed and randomized checks of proc_ctrl against a register-file reference model
module tb_proc_ctrl;
    logic        Clock = 1'b0;
    logic        Resetn, Run, Gnz;
    logic [15:0] DIN;
    logic [0:7]  Rout, Rin;
    logic        Gout, DINout, IRin, Ain, Gin, AddSub, Done;
    int tests = 0;
    int fails = 0;
    logic [15:0] R [8];
    logic [15:0] A;
    logic [15:0] G = '0;
    logic [15:0] bus;
    logic [15:0] ref_r [8];
    logic [15:0] ref_g;
    logic        gnz_force_en = 1'b0;
    logic        gnz_force = 1'b0;
    logic [22:0] outs;

    always #5 Clock = ~Clock;

    proc_ctrl dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Gnz(Gnz),
        .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin), .IRin(IRin),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done)
    );

    assign outs = {Rout, Gout, DINout, Rin, IRin, Ain, Gin, AddSub, Done};
    assign Gnz  = gnz_force_en ? gnz_force : (G != 16'd0);

    // datapath driven by the controller's outputs
    always_comb begin
        bus = '0;
        if (DINout) bus = DIN;
        else if (Gout) bus = G;
        else for (int n = 0; n < 8; n++) if (Rout[n]) bus = R[n];
    end

    always @(posedge Clock) begin
        for (int n = 0; n < 8; n++) if (Rin[n]) R[n] <= bus;
        if (Ain) A <= bus;
        if (Gin) G <= AddSub ? A - bus : A + bus;
    end

    function automatic logic [0:7] oh(input int n);
        logic [0:7] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [22:0] ov(input logic [0:7] ro, input logic go, input logic dio,
                                       input logic [0:7] ri, input logic irn, input logic an,
                                       input logic gn, input logic as, input logic dn);
        return {ro, go, dio, ri, irn, an, gn, as, dn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // executes one instruction starting at the next negedge (T0) and updates the reference model
    task automatic run_instr(input logic [15:0] word, input logic [15:0] imm);
        logic [2:0] op, x, y;
        int len;
        op  = word[8:6];
        x   = word[5:3];
        y   = word[2:0];
        len = (op == 3'd2 || op == 3'd3) ? 3 : 1;
        @(negedge Clock);
        Run = 1'b1;
        DIN = word;
        #1 chk("t0_fetch", outs, ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= len; k++) begin
            @(negedge Clock);
            Run = 1'($urandom);
            DIN = (op == 3'd1) ? imm : 16'($urandom);
            #1;
            chk("done_timing", Done, k == len);
            chk("irin_busy", IRin, 0);
            chk("sel_onehot", $onehot0({Rout, Gout, DINout}), 1);
            chk("rin_onehot", $onehot0(Rin), 1);
        end
        case (op)
            3'd0: ref_r[x] = ref_r[y];
            3'd1: ref_r[x] = imm;
            3'd2: begin ref_g = ref_r[x] + ref_r[y]; ref_r[x] = ref_g; end
            3'd3: begin ref_g = ref_r[x] - ref_r[y]; ref_r[x] = ref_g; end
`ifdef PROC_CTRL_MVNZ_EN
            3'd4: if (ref_g != 16'd0) ref_r[x] = ref_r[y];
`endif
            default: ;
        endcase
        @(posedge Clock);
        #1 chk("reg_result", R[x], ref_r[x]);
    endtask

    initial begin
        logic [15:0] w;
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = '0;
        #2 chk("rst_outs", outs, 0);
        Run = 1'b1;
        #1 chk("rst_irin", outs, ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
        // mv R0,R5
        @(negedge Clock);
        Resetn = 1'b1;
        Run    = 1'b1;
        DIN    = 16'h0005;
        #1 chk("mv_t0", outs, ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge Clock);
        Run = 1'b0;
        #1 chk("mv_t1", outs, ov(oh(5), 0, 0, oh(0), 0, 0, 0, 0, 1));
        chk("mv_rout_bits", Rout, 8'b00000100);
        @(negedge Clock);
        #1 chk("mv_back_t0", outs, 0);
        // mvi R1, 1234
        @(negedge Clock);
        Run = 1'b1;
        DIN = 16'h0048;
        #1;
        @(negedge Clock);
        Run = 1'b0;
        DIN = 16'h1234;
        #1 chk("mvi_t1", outs, ov(0, 0, 1, oh(1), 0, 0, 0, 0, 1));
        chk("mvi_bus", bus, 16'h1234);
        @(negedge Clock);
        #1 chk("mvi_r1", R[1], 16'h1234);
        // sub R2,R1
        @(negedge Clock);
        Run = 1'b1;
        DIN = 16'h00D1;
        #1;
        @(negedge Clock);
        Run = 1'b0;
        #1 chk("sub_t1", outs, ov(oh(2), 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge Clock);
        #1 chk("sub_t2", outs, ov(oh(1), 0, 0, 0, 0, 0, 1, 1, 0));
        @(negedge Clock);
        #1 chk("sub_t3", outs, ov(0, 1, 0, oh(2), 0, 0, 0, 0, 1));
        // idle in T0
        repeat (5) begin
            @(negedge Clock);
            Run = 1'b0;
            DIN = 16'($urandom);
            #1 chk("idle_t0", outs, 0);
        end
        // add R3,R4 with Run dropped in T2
        @(negedge Clock);
        Run = 1'b1;
        DIN = 16'h009C;
        #1;
        @(negedge Clock);
        #1 chk("add_t1", outs, ov(oh(3), 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge Clock);
        Run = 1'b0;
        #1 chk("add_t2", outs, ov(oh(4), 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge Clock);
        #1 chk("add_t3", outs, ov(0, 1, 0, oh(3), 0, 0, 0, 0, 1));
        // reset pulse in T2 of add
        @(negedge Clock);
        Run = 1'b1;
        DIN = 16'h009C;
        #1;
        @(negedge Clock);
        Run = 1'b0;
        #1;
        @(negedge Clock);
        #1 chk("rst_pre_t2", outs, ov(oh(4), 0, 0, 0, 0, 0, 1, 0, 0));
        #1 Resetn = 1'b0;
        #1 chk("rst_async", outs, 0);
        @(negedge Clock);
        #1 chk("rst_hold", outs, 0);
        Resetn = 1'b1;
        #1 chk("rst_release", outs, 0);
        @(negedge Clock);
        #1 chk("rst_no_t3", outs, 0);
        @(negedge Clock);
        Run = 1'b1;
        DIN = 16'h0005;
        #1 chk("rst_refetch_t0", outs, ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge Clock);
        Run = 1'b0;
        #1 chk("rst_refetch_t1", outs, ov(oh(5), 0, 0, oh(0), 0, 0, 0, 0, 1));
        // opcode 100, X=2, Y=3
        gnz_force_en = 1'b1;
        gnz_force    = 1'b0;
        @(negedge Clock);
        Run = 1'b1;
        DIN = 16'h0113;
        #1;
        @(negedge Clock);
        Run = 1'b0;
        #1 chk("op100_gnz0", outs, ov(0, 0, 0, 0, 0, 0, 0, 0, 1));
        gnz_force = 1'b1;
`ifdef PROC_CTRL_MVNZ_EN
        #1 chk("op100_gnz1", outs, ov(oh(3), 0, 0, oh(2), 0, 0, 0, 0, 1));
`else
        #1 chk("op100_gnz1", outs, ov(0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
        @(negedge Clock);
        gnz_force_en = 1'b0;
        // randomized phase: load all registers, seed G, then random instructions
        for (int r = 0; r < 8; r++) run_instr({7'd0, 3'b001, 3'(r), 3'b000}, 16'($urandom));
        run_instr({7'd0, 3'b010, 3'd0, 3'd1}, 16'd0);
        repeat (150) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge Clock);
                Run = 1'b0;
                DIN = 16'($urandom);
                #1 chk("rand_idle", outs, 0);
            end
            w = 16'($urandom);
            run_instr(w, 16'($urandom));
        end
        for (int r = 0; r < 8; r++) chk("final_regs", R[r], ref_r[r]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
